tower_collision_detector: RTL

Consumes the per-pixel drawingRequest and offsetX/offsetY stream produced by the falling-tower object generator, together with the player's drawingRequest. It decides, once per frame, whether the player was hit by a tower. It sits between the object generators and the game-control logic, and delivers a single debounced collision pulse per frame, the hit position, a saturating hit count and an invulnerability (cooldown) window.

---
 rtl/tower_collision_detector.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/tower_collision_detector.sv
// Frame-based player/tower collision detector: counts qualified overlap pixels per frame,
// raises one collision pulse per hit frame, and enforces a frame-count invulnerability window.
module tower_collision_detector #(
    parameter int TOWER_WIDTH        = 28,
    parameter int HIT_MARGIN_X       = 4,
    parameter int HIT_MARGIN_TOP     = 8,
    parameter int MIN_OVERLAP_PIXELS = 6,
    parameter int COOLDOWN_FRAMES    = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        towerDrawingRequest,
    input  logic [10:0] towerOffsetX,
    input  logic [10:0] towerOffsetY,
    input  logic        playerDrawingRequest,
    input  logic        pause,
    output logic        collision,
    output logic [10:0] hitX,
    output logic [10:0] hitY,
    output logic [3:0]  hitCount,
    output logic        invulnerable
);

    localparam int CD_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [10:0]     X_LO    = 11'(HIT_MARGIN_X);
    localparam logic [10:0]     X_HI    = 11'(TOWER_WIDTH - HIT_MARGIN_X);
    localparam logic [10:0]     Y_LO    = 11'(HIT_MARGIN_TOP);
    localparam logic [7:0]      MIN_OVL = 8'(MIN_OVERLAP_PIXELS);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
    localparam logic [CD_W-1:0] CD_ZERO = CD_W'(0);
    localparam logic            HAS_CD  = (COOLDOWN_FRAMES > 0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ARMED    = 1'b0,
        COOLDOWN = 1'b1
    } state_t;

    // Margins carve the lethal core out of the bracket; offsets are unsigned.
    function automatic logic in_hit_zone(input logic [10:0] ox, input logic [10:0] oy);
        return (ox >= X_LO) && (ox < X_HI) && (oy >= Y_LO);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'd255) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    state_t          state_r, state_nxt_s;
    logic [CD_W-1:0] cd_cnt_r, cd_cnt_nxt_s;
    logic [7:0]      overlap_cnt_r, overlap_cnt_nxt_s;
    logic            first_seen_r, first_seen_nxt_s;
    logic [10:0]     first_x_r, first_x_nxt_s;
    logic [10:0]     first_y_r, first_y_nxt_s;
    logic            collision_r;
    logic [10:0]     hit_x_r, hit_y_r;
    logic [3:0]      hit_count_r;
    logic            invulnerable_r;
    logic            counted_s;
    logic            hit_s;

    // Qualify the current pixel and the frame-boundary hit decision.
    always_comb begin
        counted_s = towerDrawingRequest & playerDrawingRequest
                  & in_hit_zone(towerOffsetX, towerOffsetY)
                  & ~pause & ~startOfFrame;
        hit_s     = startOfFrame & ~pause & (state_r == ARMED) & (overlap_cnt_r >= MIN_OVL);
    end

    // Per-frame overlap accumulation and first-pixel capture.
    always_comb begin
        overlap_cnt_nxt_s = overlap_cnt_r;
        first_seen_nxt_s  = first_seen_r;
        first_x_nxt_s     = first_x_r;
        first_y_nxt_s     = first_y_r;
        if (startOfFrame) begin
            overlap_cnt_nxt_s = 8'd0;
            first_seen_nxt_s  = 1'b0;
        end else if (counted_s) begin
            overlap_cnt_nxt_s = sat_inc8(overlap_cnt_r);
            if (!first_seen_r) begin
                first_seen_nxt_s = 1'b1;
                first_x_nxt_s    = pixelX;
                first_y_nxt_s    = pixelY;
            end else begin
                first_seen_nxt_s = first_seen_r;
            end
        end else begin
            overlap_cnt_nxt_s = overlap_cnt_r;
        end
    end

    // ARMED/COOLDOWN next state; the cooldown counter only moves on unpaused frame boundaries.
    always_comb begin
        state_nxt_s  = state_r;
        cd_cnt_nxt_s = cd_cnt_r;
        case (state_r)
            ARMED: begin
                if (hit_s && HAS_CD) begin
                    state_nxt_s  = COOLDOWN;
                    cd_cnt_nxt_s = CD_LOAD;
                end else begin
                    state_nxt_s  = ARMED;
                end
            end
            COOLDOWN: begin
                if (startOfFrame && !pause) begin
                    if (cd_cnt_r == CD_ONE) begin
                        state_nxt_s  = ARMED;
                        cd_cnt_nxt_s = CD_ZERO;
                    end else begin
                        cd_cnt_nxt_s = cd_cnt_r - CD_ONE;
                    end
                end else begin
                    state_nxt_s = COOLDOWN;
                end
            end
            default: begin
                state_nxt_s  = ARMED;
                cd_cnt_nxt_s = CD_ZERO;
            end
        endcase
    end

    // State register; reset overrides everything, including mid-frame and mid-cooldown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ARMED;
            cd_cnt_r      <= CD_ZERO;
            overlap_cnt_r <= 8'd0;
            first_seen_r  <= 1'b0;
            first_x_r     <= 11'd0;
            first_y_r     <= 11'd0;
        end else begin
            state_r       <= state_nxt_s;
            cd_cnt_r      <= cd_cnt_nxt_s;
            overlap_cnt_r <= overlap_cnt_nxt_s;
            first_seen_r  <= first_seen_nxt_s;
            first_x_r     <= first_x_nxt_s;
            first_y_r     <= first_y_nxt_s;
        end
    end

    // Registered outputs: pulse and hit position land one cycle after the boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            collision_r    <= 1'b0;
            hit_x_r        <= 11'd0;
            hit_y_r        <= 11'd0;
            hit_count_r    <= 4'd0;
            invulnerable_r <= 1'b0;
        end else begin
            collision_r    <= hit_s;
            invulnerable_r <= (state_nxt_s == COOLDOWN);
            if (hit_s) begin
                hit_x_r     <= first_x_r;
                hit_y_r     <= first_y_r;
                hit_count_r <= sat_inc4(hit_count_r);
            end else begin
                hit_x_r     <= hit_x_r;
                hit_y_r     <= hit_y_r;
                hit_count_r <= hit_count_r;
            end
        end
    end

    assign collision    = collision_r;
    assign hitX         = hit_x_r;
    assign hitY         = hit_y_r;
    assign hitCount     = hit_count_r;
    assign invulnerable = invulnerable_r;

endmodule
